// File: rtl/psum_acc_feed_if.sv
// rtl/psum_acc_feed_if.sv - psum row stream into the accumulation feeder
interface psum_acc_feed_if #(
    parameter int col     = 8,
    parameter int bw_psum = 20
);
    logic [col*bw_psum-1:0] psum_in;
    logic                   psum_valid;
    logic                   psum_ready;

    modport master (output psum_in, output psum_valid, input psum_ready);
    modport slave  (input psum_in, input psum_valid, output psum_ready);
endinterface

// File: rtl/psum_acc_feed.sv
// rtl/psum_acc_feed.sv - K-pass psum row accumulator feeding normalizer acc/div phases
// Define PSUM_SAT_EN to saturate pass additions instead of wrapping.
module psum_acc_feed #(
    parameter int col     = 8,
    parameter int bw      = 8,
    parameter int bw_psum = 2*bw+4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             len,
    input  logic [3:0]             kpass,
    psum_acc_feed_if.slave         psum,
    input  logic                   sync_ok,
    output logic [col*bw_psum-1:0] sfp_data,
    output logic                   acc,
    output logic                   div,
    output logic                   busy,
    output logic                   done
);
    localparam int depth = 16;
    localparam int W     = col*bw_psum;

    typedef enum logic [2:0] {IDLE, ACCUM, NORM, WAIT, DIV, DONE} state_t;

    state_t     state, state_d;
    logic [3:0] row, row_d, pass, pass_d;
    logic [3:0] len_q, kpass_q;
    logic [W-1:0] buffer [depth];
    logic [W-1:0] cur_row, new_row, out_src;
    logic       xfer, buf_we, acc_d, div_d;

    assign psum.psum_ready = (state == ACCUM);
    assign xfer            = psum.psum_valid && psum.psum_ready;
    assign busy            = (state != IDLE);
    assign cur_row         = buffer[row];

    for (genvar i = 0; i < col; i++) begin : g_lane
        logic signed [bw_psum-1:0] a, b, s;
        assign a = cur_row[i*bw_psum +: bw_psum];
        assign b = psum.psum_in[i*bw_psum +: bw_psum];
`ifdef PSUM_SAT_EN
        logic signed [bw_psum:0] wide;
        assign wide = {a[bw_psum-1], a} + {b[bw_psum-1], b};
        // Overflow shows as disagreement between the guard bit and the sign bit
        assign s = (wide[bw_psum] != wide[bw_psum-1])
                 ? (wide[bw_psum] ? {1'b1, {(bw_psum-1){1'b0}}} : {1'b0, {(bw_psum-1){1'b1}}})
                 : wide[bw_psum-1:0];
`else
        assign s = a + b;
`endif
        assign new_row[i*bw_psum +: bw_psum] = (pass == 4'd0) ? b : s;
    end

    always_comb begin
        state_d = state;
        row_d   = row;
        pass_d  = pass;
        buf_we  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    row_d   = 4'd0;
                    pass_d  = 4'd0;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    buf_we = 1'b1;
                    if (row == len_q) begin
                        row_d = 4'd0;
                        if (pass == kpass_q) begin
                            pass_d  = 4'd0;
                            state_d = NORM;
                        end else begin
                            pass_d = pass + 4'd1;
                        end
                    end else begin
                        row_d = row + 4'd1;
                    end
                end
            end
            NORM, DIV: begin
                if (row == len_q) begin
                    row_d   = 4'd0;
                    state_d = (state == NORM) ? WAIT : DONE;
                end else begin
                    row_d = row + 4'd1;
                end
            end
            WAIT:    if (sync_ok) state_d = DIV;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        acc_d = (state_d == NORM);
        div_d = (state_d == DIV);
        // With a single-row tile, row 0 is written on the same edge it is first presented
        out_src = (buf_we && row == row_d) ? new_row : buffer[row_d];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            row      <= 4'd0;
            pass     <= 4'd0;
            len_q    <= 4'd0;
            kpass_q  <= 4'd0;
            acc      <= 1'b0;
            div      <= 1'b0;
            done     <= 1'b0;
            sfp_data <= '0;
        end else begin
            state <= state_d;
            row   <= row_d;
            pass  <= pass_d;
            if (state == IDLE && start) begin
                len_q   <= len;
                kpass_q <= kpass;
            end
            acc      <= acc_d;
            div      <= div_d;
            done     <= (state_d == DONE);
            sfp_data <= (acc_d || div_d) ? out_src : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buffer[row] <= new_row;
    end
endmodule

// File: tb/tb_psum_acc_feed.sv
// tb/tb_psum_acc_feed.sv - scoreboard bench for psum_acc_feed
module tb_psum_acc_feed;
    localparam int COL = 8;
    localparam int BP  = 20;
    localparam int W   = COL*BP;

    logic         clk = 1'b0;
    logic         reset, start, sync_ok;
    logic [3:0]   len, kpass;
    logic [W-1:0] sfp_data;
    logic         acc, div, busy, done;

    psum_acc_feed_if #(.col(COL), .bw_psum(BP)) psum ();

    psum_acc_feed #(.col(COL), .bw(8), .bw_psum(BP)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .kpass(kpass),
        .psum(psum), .sync_ok(sync_ok), .sfp_data(sfp_data),
        .acc(acc), .div(div), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_div;
        logic [W-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         e;
    int           checks = 0, errors = 0;
    int           done_seen = 0, done_exp = 0, acc_cnt = 0, div_cnt = 0;
    logic [W-1:0] stim [16][16];

    task automatic check(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic longint lane_of(input logic [W-1:0] v, input int i);
        logic [BP-1:0] x;
        x = v[i*BP +: BP];
        return longint'($signed(x));
    endfunction

    function automatic longint addm(input longint a, input longint b);
        longint s;
        s = a + b;
`ifdef PSUM_SAT_EN
        if (s > (64'sd1 <<< (BP-1)) - 1) s = (64'sd1 <<< (BP-1)) - 1;
        if (s < -(64'sd1 <<< (BP-1)))    s = -(64'sd1 <<< (BP-1));
`else
        s = s & ((64'sd1 <<< BP) - 1);
        if (s >= (64'sd1 <<< (BP-1))) s = s - (64'sd1 <<< BP);
`endif
        return s;
    endfunction

    task automatic fill_random();
        logic [BP-1:0] x;
        for (int p = 0; p < 16; p++)
            for (int r = 0; r < 16; r++)
                for (int i = 0; i < COL; i++) begin
                    x = BP'($urandom());
                    stim[p][r][i*BP +: BP] = x;
                end
    endtask

    task automatic set_lane(input int p, input int r, input int i, input longint v);
        longint t;
        t = v;
        stim[p][r][i*BP +: BP] = t[BP-1:0];
    endtask

    // Reference: per row and lane, first pass loads, later passes add
    task automatic push_model(input int l, input int k);
        longint m [16][COL];
        longint t;
        exp_t   x;
        for (int p = 0; p <= k; p++)
            for (int r = 0; r <= l; r++)
                for (int i = 0; i < COL; i++)
                    m[r][i] = (p == 0) ? lane_of(stim[p][r], i) : addm(m[r][i], lane_of(stim[p][r], i));
        for (int ph = 0; ph < 2; ph++)
            for (int r = 0; r <= l; r++) begin
                x.is_div = ph[0];
                for (int i = 0; i < COL; i++) begin
                    t = m[r][i];
                    x.data[i*BP +: BP] = t[BP-1:0];
                end
                exp_q.push_back(x);
            end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check(!(acc && div), "acc_div_exclusive", {acc, div}, 0);
            if (acc || div) begin
                acc_cnt += int'(acc);
                div_cnt += int'(div);
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_row", sfp_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(e.is_div == div, "phase", div, e.is_div);
                    check(e.data == sfp_data, "row_data", sfp_data, e.data);
                end
            end else begin
                check(sfp_data == '0, "idle_sfp_zero", sfp_data, 0);
            end
            if (done) done_seen++;
        end
    end

    task automatic run_tile(input int l, input int k, input bit gaps, input bit early, input int abort_at,
                            input bit probe_en, input int plane, input logic [BP-1:0] pval, input string tag);
        int n, w;
        bit rdy, first_gap;
        push_model(l, k);
        acc_cnt = 0;
        div_cnt = 0;
        sync_ok = early;
        @(posedge clk); #1;
        start = 1'b1; len = 4'(l); kpass = 4'(k);
        @(posedge clk); #1;
        start = 1'b0; len = 4'($urandom()); kpass = 4'($urandom());
        first_gap = 1'b1;
        for (int p = 0; p <= k; p++)
            for (int r = 0; r <= l; r++) begin
                psum.psum_in = stim[p][r];
                psum.psum_valid = 1'b1;
                n = 0; rdy = 1'b0;
                while (!rdy && n < 50) begin
                    @(negedge clk); rdy = psum.psum_ready;
                    @(posedge clk); #1; n++;
                end
                check(rdy, {tag, "_xfer_ready"}, rdy, 1);
                if (gaps) begin
                    psum.psum_valid = 1'b0;
                    psum.psum_in = ~stim[p][r];
                    repeat ($urandom_range(1, 3)) begin
                        if (first_gap) start = 1'b1;
                        @(posedge clk); #1;
                        start = 1'b0; first_gap = 1'b0;
                    end
                end
            end
        // Junk offered outside ACCUM must not reach the buffer
        psum.psum_valid = gaps;
        psum.psum_in = ~stim[0][0];
        n = 0;
        do begin @(negedge clk); n++; end while (!acc && n < 50);
        check(acc, {tag, "_acc_start"}, acc, 1);
        if (probe_en) check(sfp_data[plane*BP +: BP] == pval, {tag, "_norm_probe"}, sfp_data[plane*BP +: BP], pval);
        n = 0;
        while (acc && n < 50) begin @(negedge clk); n++; end
        if (!early) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sync_ok = 1'b1;
        end
        w = 0; n = 0;
        while (!div && n < 50) begin w++; @(negedge clk); n++; end
        check(div, {tag, "_div_start"}, div, 1);
        if (early) check(w == 1, {tag, "_wait_one_cycle"}, w, 1);
        if (probe_en) check(sfp_data[plane*BP +: BP] == pval, {tag, "_div_probe"}, sfp_data[plane*BP +: BP], pval);
        if (!early) sync_ok = 1'b0;
        if (abort_at >= 0) begin
            repeat (abort_at) @(negedge clk);
            #1 reset = 1'b1;
            exp_q.delete();
            #1;
            check(!acc && !div && !done && !busy, {tag, "_reset_strobes"}, {acc, div, done, busy}, 0);
            check(!psum.psum_ready, {tag, "_reset_ready"}, psum.psum_ready, 0);
            check(sfp_data == '0, {tag, "_reset_sfp"}, sfp_data, 0);
            repeat (2) @(posedge clk);
            #1 reset = 1'b0;
            psum.psum_valid = 1'b0;
            sync_ok = 1'b0;
            return;
        end
        n = 0;
        while (!done && n < 50) begin @(negedge clk); n++; end
        check(done, {tag, "_done_pulse"}, done, 1);
        done_exp++;
        check(acc_cnt == l + 1, {tag, "_acc_cycles"}, acc_cnt, l + 1);
        check(div_cnt == l + 1, {tag, "_div_cycles"}, div_cnt, l + 1);
        @(negedge clk);
        check(!done, {tag, "_done_one_cycle"}, done, 0);
        check(!busy, {tag, "_idle_after_done"}, busy, 0);
        check(exp_q.size() == 0, {tag, "_queue_drained"}, exp_q.size(), 0);
        psum.psum_valid = 1'b0;
        sync_ok = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int l, k;
        reset = 1'b1; start = 1'b0; sync_ok = 1'b0; len = '0; kpass = '0;
        psum.psum_valid = 1'b0; psum.psum_in = '0;
        repeat (2) @(posedge clk); #1;
        check(!acc && !div && !done && !busy, "reset_strobes", {acc, div, done, busy}, 0);
        check(!psum.psum_ready, "reset_ready", psum.psum_ready, 0);
        check(sfp_data == '0, "reset_sfp", sfp_data, 0);
        reset = 1'b0;

        fill_random();
        set_lane(0, 0, 0, 5); set_lane(0, 1, 0, -7); set_lane(0, 2, 0, 100); set_lane(0, 3, 0, 0);
        run_tile(3, 0, 1'b0, 1'b0, -1, 1'b1, 0, 20'd5, "v1");

        fill_random();
        set_lane(0, 0, 3, 10); set_lane(1, 0, 3, 20); set_lane(2, 0, 3, -3);
        run_tile(1, 2, 1'b0, 1'b0, -1, 1'b1, 3, 20'd27, "v2");

        fill_random();
        set_lane(0, 0, 0, (64'sd1 <<< 19) - 1); set_lane(1, 0, 0, 1);
`ifdef PSUM_SAT_EN
        run_tile(0, 1, 1'b0, 1'b0, -1, 1'b1, 0, 20'h7FFFF, "v3");
`else
        run_tile(0, 1, 1'b0, 1'b0, -1, 1'b1, 0, 20'h80000, "v3");
`endif

        fill_random();
        run_tile(2, 1, 1'b1, 1'b1, -1, 1'b0, 0, '0, "v4");

        fill_random();
        run_tile(7, 0, 1'b0, 1'b0, 2, 1'b0, 0, '0, "v5a");
        fill_random();
        run_tile(0, 0, 1'b0, 1'b0, -1, 1'b0, 0, '0, "v5b");

        fill_random();
        run_tile(15, 15, 1'b0, 1'b0, -1, 1'b0, 0, '0, "v6");

        for (int t = 0; t < 3; t++) begin
            fill_random();
            l = $urandom_range(0, 15);
            k = $urandom_range(0, 15);
            run_tile(l, k, t[0], 1'b0, -1, 1'b0, 0, '0, "rnd");
        end

        repeat (3) @(negedge clk);
        check(done_seen == done_exp, "done_count", done_seen, done_exp);
        check(exp_q.size() == 0, "final_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
